// File: rtl/mips_control.sv
// Multi-cycle fetch/decode/execute/writeback sequencer producing ALU and register-file controls.
// Optional `beq` support is enabled by defining MIPS_CTRL_BRANCH_EN.
module mips_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] pc,
  output logic [11:0] alu_ctrl,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  input  logic        alu_zero,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  output logic [4:0]  rf_waddr,
  output logic        rf_we,
  output logic        halted,
  output logic [2:0]  o_dbg_state
);

  // Fetch handshake: an instruction is transferred on any cycle where
  // fetch_req && fetch_ack are both high; fetch_addr is held until then.
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_TRAP      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [11:0] r_alu_ctrl;
  logic        r_alu_src_imm;
  logic [31:0] r_imm;
  logic [4:0]  r_waddr;
  logic        r_is_beq;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [31:0] w_sext;
  logic        w_is_addi;
  logic        w_is_add;
  logic        w_is_beq;
  logic        w_take_branch;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;

  assign w_opcode        = r_instr[31:26];
  assign w_funct         = r_instr[5:0];
  assign w_sext          = {{16{r_instr[15]}}, r_instr[15:0]};
  assign w_is_addi       = (w_opcode == 6'b001000);
  assign w_is_add        = (w_opcode == 6'b000000) && (w_funct == 6'b100000);
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + {r_imm[29:0], 2'b00};

`ifdef MIPS_CTRL_BRANCH_EN
  assign w_is_beq      = (w_opcode == 6'b000100);
  assign w_take_branch = alu_zero;
`else
  logic w_unused_zero;
  assign w_unused_zero = alu_zero;
  assign w_is_beq      = 1'b0;
  assign w_take_branch = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    fetch_req = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        fetch_req = !reset;
        if (fetch_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_addi || w_is_add || w_is_beq) w_next = S_EXECUTE;
        else                                   w_next = S_TRAP;
      end
      S_EXECUTE: w_next = r_is_beq ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: begin
        // Writes to $0 are architecturally discarded, so no strobe.
        rf_we  = (r_waddr != 5'd0) && !reset;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        halted = 1'b1;
        w_next = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_alu_ctrl    <= 12'd0;
      r_alu_src_imm <= 1'b0;
      r_imm         <= 32'd0;
      r_waddr       <= 5'd0;
      r_is_beq      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: if (fetch_ack) r_instr <= fetch_data;
        S_DECODE: begin
          if (w_is_addi) begin
            r_alu_ctrl    <= 12'b001000_000000;
            r_alu_src_imm <= 1'b1;
            r_imm         <= w_sext;
            r_waddr       <= r_instr[20:16];
            r_is_beq      <= 1'b0;
          end else if (w_is_add) begin
            r_alu_ctrl    <= 12'b000000_100000;
            r_alu_src_imm <= 1'b0;
            r_imm         <= w_sext;
            r_waddr       <= r_instr[15:11];
            r_is_beq      <= 1'b0;
          end else if (w_is_beq) begin
            r_alu_ctrl    <= 12'b000100_000000;
            r_alu_src_imm <= 1'b0;
            r_imm         <= w_sext;
            r_is_beq      <= 1'b1;
          end
        end
        S_EXECUTE: if (r_is_beq) r_pc <= w_take_branch ? w_branch_target : w_pc_plus4;
        S_WRITEBACK: r_pc <= w_pc_plus4;
        default: ;
      endcase
    end
  end

  assign pc          = r_pc;
  assign fetch_addr  = r_pc;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_src_imm = r_alu_src_imm;
  assign imm         = r_imm;
  assign rf_waddr    = r_waddr;
  assign rf_raddr1   = r_instr[25:21];
  assign rf_raddr2   = r_instr[20:16];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mips_control.sv
// Directed testbench for mips_control: instruction vectors with hand-computed expectations.
module tb_mips_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_data = 32'd0;
  logic [31:0] pc;
  logic [11:0] alu_ctrl;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic        alu_zero = 1'b0;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we;
  logic        halted;
  logic [2:0]  dbg_state;

  // Second instance free-runs addi from a PC just below the wrap point.
  logic        w2_fetch_req, w2_alu_src_imm, w2_rf_we, w2_halted;
  logic [31:0] w2_fetch_addr, w2_pc, w2_imm;
  logic [11:0] w2_alu_ctrl;
  logic [4:0]  w2_raddr1, w2_raddr2, w2_waddr;
  logic [2:0]  w2_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_control #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .pc(pc), .alu_ctrl(alu_ctrl),
    .alu_src_imm(alu_src_imm), .imm(imm), .alu_zero(alu_zero),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .halted(halted), .o_dbg_state(dbg_state)
  );

  mips_control #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .fetch_req(w2_fetch_req), .fetch_addr(w2_fetch_addr),
    .fetch_ack(1'b1), .fetch_data(32'h2001_0001), .pc(w2_pc), .alu_ctrl(w2_alu_ctrl),
    .alu_src_imm(w2_alu_src_imm), .imm(w2_imm), .alu_zero(1'b0),
    .rf_raddr1(w2_raddr1), .rf_raddr2(w2_raddr2), .rf_waddr(w2_waddr),
    .rf_we(w2_rf_we), .halted(w2_halted), .o_dbg_state(w2_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction (after `waits` idle fetch cycles) and runs until
  // the next fetch or a trap; returns cycles spent and rf_we pulses seen.
  task automatic do_instr(input logic [31:0] word, input int waits, input logic zero,
                          output int cyc, output int wes);
    logic [31:0] addr0;
    cyc      = 0;
    wes      = 0;
    alu_zero = zero;
    addr0    = fetch_addr;
    for (int i = 0; i < waits; i++) begin
      fetch_ack = 1'b0;
      tick();
      cyc++;
      check("wait_req", {31'd0, fetch_req}, 32'd1);
      check("wait_addr_stable", fetch_addr, addr0);
    end
    fetch_ack  = 1'b1;
    fetch_data = word;
    tick();
    cyc++;
    fetch_ack  = 1'b0;
    fetch_data = 32'd0;
    #1;
    for (int k = 0; k < 12 && !fetch_req && !halted; k++) begin
      cyc++;
      if (rf_we) wes++;
      tick();
    end
    if (!fetch_req && !halted) check("instr_timeout", 32'd0, 32'd1);
  endtask

  int cyc, wes, req_cnt, we_cnt;

  initial begin
    // Reset
    tick();
    tick();
    check("req_during_reset", {31'd0, fetch_req}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_req", {31'd0, fetch_req}, 32'd1);
    check("rst_addr", fetch_addr, 32'h0);
    check("rst_alu_ctrl", {20'd0, alu_ctrl}, 32'd0);
    check("rst_imm", imm, 32'd0);
    check("rst_flags", {28'd0, alu_src_imm, rf_we, halted, |rf_waddr}, 32'd0);

    // addi $9,$0,5 with immediate ack
    do_instr(32'h2009_0005, 0, 1'b0, cyc, wes);
    check("addi_cycles", cyc, 32'd4);
    check("addi_we", wes, 32'd1);
    check("addi_ctrl", {20'd0, alu_ctrl}, 32'h200);
    check("addi_src_imm", {31'd0, alu_src_imm}, 32'd1);
    check("addi_imm", imm, 32'd5);
    check("addi_waddr", {27'd0, rf_waddr}, 32'd9);
    check("addi_next_addr", fetch_addr, 32'h4);
    check("wrap_pc", w2_pc, 32'h0);

    // add $11,$9,$10 with two wait cycles
    do_instr(32'h012A_5820, 2, 1'b0, cyc, wes);
    check("add_cycles", cyc, 32'd6);
    check("add_we", wes, 32'd1);
    check("add_ctrl", {20'd0, alu_ctrl}, 32'h020);
    check("add_src_imm", {31'd0, alu_src_imm}, 32'd0);
    check("add_raddr1", {27'd0, rf_raddr1}, 32'd9);
    check("add_raddr2", {27'd0, rf_raddr2}, 32'd10);
    check("add_waddr", {27'd0, rf_waddr}, 32'd11);
    check("add_next_addr", fetch_addr, 32'h8);

    // addi to $0: no write strobe, pc still advances
    do_instr(32'h2000_0007, 0, 1'b0, cyc, wes);
    check("addi0_we", wes, 32'd0);
    check("addi0_waddr", {27'd0, rf_waddr}, 32'd0);
    check("addi0_next_addr", fetch_addr, 32'hC);

    // Pad to pc=0x10 for the branch vectors
    do_instr(32'h2008_0001, 0, 1'b0, cyc, wes);
    check("pad_addr", fetch_addr, 32'h10);

`ifdef MIPS_CTRL_BRANCH_EN
    do_instr(32'h1000_FFFF, 0, 1'b1, cyc, wes);
    check("beq_t_cycles", cyc, 32'd3);
    check("beq_t_we", wes, 32'd0);
    check("beq_t_ctrl", {20'd0, alu_ctrl}, 32'h100);
    check("beq_t_imm", imm, 32'hFFFF_FFFF);
    check("beq_t_addr", fetch_addr, 32'h10);
    do_instr(32'h1000_FFFF, 0, 1'b0, cyc, wes);
    check("beq_nt_we", wes, 32'd0);
    check("beq_nt_addr", fetch_addr, 32'h14);
`else
    do_instr(32'h1000_FFFF, 0, 1'b1, cyc, wes);
    check("beq_trap_halted", {31'd0, halted}, 32'd1);
    check("beq_trap_pc", pc, 32'h10);
    check("beq_trap_we", wes, 32'd0);
`endif
    alu_zero = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    // Undefined opcode traps and stays put, ignoring acks
    do_instr(32'hFC00_0000, 0, 1'b0, cyc, wes);
    check("trap_halted", {31'd0, halted}, 32'd1);
    check("trap_state", {29'd0, dbg_state}, 32'd4);
    req_cnt    = 0;
    we_cnt     = 0;
    fetch_ack  = 1'b1;
    fetch_data = 32'h2009_0005;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_req) req_cnt++;
      if (rf_we) we_cnt++;
    end
    fetch_ack = 1'b0;
    check("trap_req_quiet", req_cnt, 32'd0);
    check("trap_we_quiet", we_cnt, 32'd0);
    check("trap_pc_hold", pc, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("trap_rst_halted", {31'd0, halted}, 32'd0);
    check("trap_rst_addr", fetch_addr, 32'h0);

    // Reset over a pending fetch with a same-cycle ack
    for (int i = 0; i < 3; i++) tick();
    check("pend_req", {31'd0, fetch_req}, 32'd1);
    reset      = 1'b1;
    fetch_ack  = 1'b1;
    fetch_data = 32'h2009_0005;
    tick();
    reset     = 1'b0;
    fetch_ack = 1'b0;
    #1;
    check("pend_state", {29'd0, dbg_state}, 32'd0);
    check("pend_addr", fetch_addr, 32'h0);
    check("pend_we", {31'd0, rf_we}, 32'd0);
    check("pend_discard", {27'd0, rf_raddr2}, 32'd0);

    // Reset arriving during writeback suppresses the strobe
    fetch_ack  = 1'b1;
    fetch_data = 32'h2009_0005;
    tick();
    fetch_ack = 1'b0;
    tick();
    tick();
    check("wb_state", {29'd0, dbg_state}, 32'd3);
    check("wb_we_before", {31'd0, rf_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("wb_we_in_reset", {31'd0, rf_we}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("wb_rst_pc", pc, 32'h0);
    check("wb_rst_state", {29'd0, dbg_state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_control.md
# mips_control

Multi-cycle instruction sequencer for the MIPS core. It fetches instruction words over a request/acknowledge port and decodes them into the 12-bit `{opcode, funct}` control word consumed by the ALU. It drives register-file addresses and write enables, updates the program counter, and uses the ALU `zero` flag for branches. It sits between instruction memory and the ALU/register-file datapath.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  out  1  instruction fetch request.
- `fetch_addr`  out  32  fetch address, always equal to `pc`.
- `fetch_ack`  in  1  fetch data valid this cycle.
- `fetch_data`  in  32  instruction word, sampled when `fetch_req && fetch_ack`.
- `pc`  out  32  current program counter.
- `alu_ctrl`  out  12  ALU control word `{opcode[5:0], funct[5:0]}`.
- `alu_src_imm`  out  1  1 = ALU src2 takes `imm`, 0 = src2 takes register rt.
- `imm`  out  32  sign-extended `instr[15:0]`.
- `alu_zero`  in  1  ALU zero flag.
- `rf_raddr1`  out  5  rs = `instr[25:21]`.
- `rf_raddr2`  out  5  rt = `instr[20:16]`.
- `rf_waddr`  out  5  destination register.
- `rf_we`  out  1  register-file write strobe, one-cycle pulse.
- `halted`  out  1  trap flag for unsupported instruction.

## Operation
- State machine: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- FETCH:
  - `fetch_req`=1 until the ack cycle.
  - On `fetch_ack`, `fetch_data` is latched into the instruction register and the state moves to DECODE.
  - `fetch_ack` is ignored when `fetch_req`=0.
- DECODE: the instruction is classified and `alu_ctrl`, `alu_src_imm`, `imm`, `rf_waddr` are registered.
  - `addi` (opcode `001000`): `alu_ctrl`=`12'b001000_000000`, `alu_src_imm`=1, `rf_waddr`=rt.
  - `add` (opcode `000000`, funct `100000`): `alu_ctrl`=`12'b000000_100000`, `alu_src_imm`=0, `rf_waddr`=rd (`instr[15:11]`).
  - `beq` (opcode `000100`, only with the macro): `alu_ctrl`=`12'b000100_000000`, `alu_src_imm`=0.
  - Any other encoding goes to TRAP.
- EXECUTE: ALU result settles.
  - For `beq`, `alu_zero` is sampled. If 1: `pc <= pc + 4 + (imm << 2)`, else `pc <= pc + 4`. Next state FETCH (no WRITEBACK).
  - For other instructions, next state WRITEBACK.
- WRITEBACK:
  - `rf_we`=1 for exactly this cycle, except when `rf_waddr`=0, where `rf_we` stays 0.
  - `pc <= pc + 4`; next state FETCH.
- TRAP:
  - `halted`=1, `fetch_req`=0, `rf_we`=0.
  - `pc` holds the trapping instruction's address.
  - The block stays in TRAP until reset.
- Arithmetic: all PC arithmetic is 32-bit modulo, so `32'hFFFF_FFFC + 4` = `0`. Branch offset is sign-extended; negative offsets are legal.
- `alu_ctrl`, `alu_src_imm`, `imm`, `rf_waddr` hold from the end of DECODE until the next DECODE. `rf_raddr1/2` follow the instruction register combinationally.

## Timing
- Reset values:
  - state FETCH; `pc`=`RESET_PC`.
  - instruction register, `alu_ctrl`, `imm`, `rf_waddr` all 0.
  - `alu_src_imm`=0, `rf_we`=0, `halted`=0.
  - `fetch_req`=0 during reset, 1 in the first cycle after `reset` deasserts.
- Latency with same-cycle ack:
  - `addi`/`add`: 4 cycles per instruction.
  - `beq`: 3 cycles per instruction.
- Each fetch wait cycle (req=1, ack=0) adds one cycle. `fetch_addr` is stable while waiting.
- `pc` updates on the WRITEBACK edge (or the EXECUTE edge for `beq`), so the next FETCH presents the new address.
- Reset mid-operation, any state including a pending fetch: the next cycle is FETCH at `RESET_PC`. The old ack is discarded, and any pending `rf_we` is suppressed.

## Configuration
- `MIPS_CTRL_BRANCH_EN` defined: `beq` is decoded and executed as above.
- `MIPS_CTRL_BRANCH_EN` undefined: opcode `000100` is unsupported and goes to TRAP. The `alu_zero` input is unused.

## Test plan
- Reset, then ack immediately with `fetch_data`=`32'h2009_0005` (addi $9,$0,5).
  - `alu_ctrl`=`12'h200`, `alu_src_imm`=1, `imm`=5, `rf_waddr`=9.
  - `rf_we` pulses in cycle 4; next `fetch_addr`=4.
- `add` `32'h012A_5820` (add $11,$9,$10).
  - `alu_ctrl`=`12'h020`, `rf_raddr1`=9, `rf_raddr2`=10, `rf_waddr`=11, `rf_we` one pulse.
- `beq` `32'h1000_FFFF` at pc=`32'h10` with `alu_zero`=1 → next `fetch_addr`=`32'h10`, no `rf_we`.
  - With `alu_zero`=0 → `32'h14`.
  - Without the macro → `halted`=1, `pc`=`32'h10`.
- `addi` to $0 (`32'h2000_0007`) → `rf_we` never asserted; `pc` advances by 4.
- Undefined opcode `32'hFC00_0000` → `halted`=1, `fetch_req` stays 0 for 20 cycles. Then `reset` → `halted`=0, `fetch_addr`=`RESET_PC`.
- Hold `fetch_ack`=0 for 3 cycles, then assert `reset` with `fetch_ack`=1 in the same cycle → ack ignored; post-reset `fetch_addr`=`RESET_PC`, `rf_we`=0.
